// File: rtl/input_buffer.sv
// Router input port: first-word-fall-through flit FIFO plus a packet-framing FSM
// that requests the crossbar for whole packets and discards malformed flits.
module input_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              grant,
    output logic [FLIT_W-1:0] data_out,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              req,
    output logic              err,
    output logic [7:0]        drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [2:0] TYPE_HEAD = 3'b001;
    localparam logic [2:0] TYPE_BODY = 3'b010;
    localparam logic [2:0] TYPE_TAIL = 3'b100;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [7:0]        drop_q, drop_d;

    logic              full;
    logic              empty;
    logic              wr_en;
    logic              pop;
    logic              drop_inc;
    logic [FLIT_W-1:0] head_data;
    logic [2:0]        head_type;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign ready_out = ~full;
    // A flit offered during reset is never stored, whatever the FIFO state was.
    assign wr_en     = valid_in & ~full & ~rst;

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];
    assign head_type = head_data[FLIT_W-1 -: 3];

    assign data_out  = head_data;
    assign flit_id   = head_type;
    assign length    = head_data[11:0];
    assign err       = err_q;
    assign drop_cnt  = drop_q;

    // NOTE: storage is deliberately not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Packet framing. In ACTIVE nothing happens without grant, including error handling,
    // so a stalled packet keeps its context until the crossbar serves this port again.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d  = state_q;
        pop      = 1'b0;
        req      = 1'b0;
        err_d    = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (head_type == TYPE_HEAD) begin
                        req = 1'b1;
                        if (grant) begin
                            pop     = 1'b1;
                            state_d = ACTIVE;
                        end
                    end else begin
                        pop      = 1'b1;
                        err_d    = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                req = 1'b1;
                if (grant && !empty) begin
                    case (head_type)
                        TYPE_BODY: pop = 1'b1;
                        TYPE_TAIL: begin
                            pop     = 1'b1;
                            state_d = IDLE;
                        end
                        TYPE_HEAD: begin
                            // Missing tail: leave the header in place to open a new packet.
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                        default: begin
                            pop      = 1'b1;
                            err_d    = 1'b1;
                            drop_inc = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop_inc && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            err_q    <= 1'b0;
            drop_q   <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: a queue-based scoreboard tracks stored flits,
// packet state and drop count; each scenario task compares DUT outputs against it.
module tb_input_buffer;

    localparam int DEPTH  = 4;
    localparam int FLIT_W = 32;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;
    localparam logic [2:0] BAD  = 3'b111;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              grant;
    logic [FLIT_W-1:0] data_out;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              req;
    logic              err;
    logic [7:0]        drop_cnt;

    input_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .grant    (grant),
        .data_out (data_out),
        .flit_id  (flit_id),
        .length   (length),
        .req      (req),
        .err      (err),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: flits pushed when a write is accepted, popped when the packet logic consumes them.
    logic [FLIT_W-1:0] sb_q[$];
    bit                m_active;
    bit                m_err;
    int                m_drop;

    function automatic logic [FLIT_W-1:0] flit(input logic [2:0] t, input logic [11:0] len,
                                               input logic [16:0] tag);
        return {t, tag, len};
    endfunction

    function automatic logic [FLIT_W-1:0] exp_data();
        return (sb_q.size() > 0) ? sb_q[0] : '0;
    endfunction

    function automatic logic exp_req();
        logic [FLIT_W-1:0] h;
        h = exp_data();
        return m_active || ((sb_q.size() > 0) && (h[FLIT_W-1 -: 3] == HDR));
    endfunction

    // Drive one clock cycle from a falling edge to the next, advancing the scoreboard.
    task automatic step(input logic r, input logic v, input logic [FLIT_W-1:0] d, input logic g);
        logic [2:0] h;
        bit pop, wr, nerr, ndrop, nact;
        rst = r; valid_in = v; data_in = d; grant = g;
        pop = 0; nerr = 0; ndrop = 0; nact = m_active;
        wr = v && (sb_q.size() < DEPTH);
        if (sb_q.size() > 0) begin
            h = sb_q[0][FLIT_W-1 -: 3];
            if (!m_active) begin
                if (h == HDR) begin
                    if (g) begin pop = 1; nact = 1; end
                end else begin
                    pop = 1; nerr = 1; ndrop = 1;
                end
            end else if (g) begin
                if (h == BODY) pop = 1;
                else if (h == TAIL) begin pop = 1; nact = 0; end
                else if (h == HDR) begin nerr = 1; nact = 0; end
                else begin pop = 1; nerr = 1; ndrop = 1; end
            end
        end
        @(posedge clk);
        if (r) begin
            sb_q.delete(); m_active = 0; m_err = 0; m_drop = 0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (wr) sb_q.push_back(d);
            m_active = nact;
            m_err    = nerr;
            if (ndrop && m_drop < 255) m_drop++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, flit(HDR, 12'h00A, 17'h1), 1'b0);
        n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%b exp=1", ready_out); end
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req got=%b exp=0", req); end
        n_cmp++; if (err !== 1'b0 || drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err_drop err=%b drop=%0d exp 0/0", err, drop_cnt); end
        n_cmp++; if (data_out !== '0 || flit_id !== 3'd0 || length !== 12'd0) begin n_bad++; $display("FAIL rst_outputs data=%h id=%b len=%h exp 0", data_out, flit_id, length); end
        step(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (data_out !== '0 || req !== 1'b0) begin n_bad++; $display("FAIL rst_no_store data=%h req=%b exp 0/0", data_out, req); end
    endtask

    task automatic test_packet();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, flit(HDR, 12'h005, 17'h10), 1'b0);
        n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL pkt_req_rise got=%b exp=1", req); end
        n_cmp++; if (flit_id !== HDR || length !== 12'h005) begin n_bad++; $display("FAIL pkt_hdr_head id=%b len=%h exp 001/005", flit_id, length); end
        step(1'b0, 1'b1, flit(BODY, 12'h0FF, 17'h11), 1'b0);
        step(1'b0, 1'b1, flit(TAIL, 12'h0EE, 17'h12), 1'b0);
        n_cmp++; if (data_out !== exp_data() || length !== 12'h005) begin n_bad++; $display("FAIL pkt_hdr_held data=%h exp=%h len=%h", data_out, exp_data(), length); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (flit_id !== BODY || req !== 1'b1) begin n_bad++; $display("FAIL pkt_body_head id=%b req=%b exp 010/1", flit_id, req); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (flit_id !== TAIL || data_out !== exp_data()) begin n_bad++; $display("FAIL pkt_tail_head id=%b data=%h exp 100/%h", flit_id, data_out, exp_data()); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (req !== 1'b0 || data_out !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL pkt_done req=%b data=%h err=%b exp 0/0/0", req, data_out, err); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [5];
        seq[0] = HDR; seq[1] = BODY; seq[2] = BODY; seq[3] = TAIL; seq[4] = BODY;
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, flit(seq[i], 12'(i + 3), 17'(32 + i)), 1'b0);
            n_cmp++; if (ready_out !== (i < 3)) begin n_bad++; $display("FAIL b2b_ready write=%0d got=%b exp=%b", i + 1, ready_out, (i < 3)); end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_cmp++; if (data_out !== exp_data() || req !== exp_req()) begin n_bad++; $display("FAIL b2b_drain cyc=%0d data=%h exp=%h req=%b exp=%b", i, data_out, exp_data(), req, exp_req()); end
            if (i == 2) begin
                n_cmp++; if (flit_id !== TAIL) begin n_bad++; $display("FAIL b2b_tail_at_head id=%b exp=100", flit_id); end
            end
        end
        n_cmp++; if (data_out !== '0 || req !== 1'b0 || ready_out !== 1'b1) begin n_bad++; $display("FAIL b2b_fifth_dropped data=%h req=%b rdy=%b exp 0/0/1", data_out, req, ready_out); end
        // Full FIFO with a pop in the same cycle still refuses the write.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, flit(seq[i], 12'h1, 17'(64 + i)), 1'b0);
        step(1'b0, 1'b1, flit(BODY, 12'h2, 17'h99), 1'b1);
        n_cmp++; if (data_out !== exp_data() || ready_out !== 1'b1) begin n_bad++; $display("FAIL full_rd_wr data=%h exp=%h rdy=%b", data_out, exp_data(), ready_out); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (data_out !== '0 || req !== 1'b0) begin n_bad++; $display("FAIL full_write_ignored data=%h req=%b exp 0/0", data_out, req); end
    endtask

    task automatic test_stray_body();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, flit(BODY, 12'h7, 17'h200), 1'b0);
        n_cmp++; if (req !== 1'b0 || flit_id !== BODY) begin n_bad++; $display("FAIL stray_head req=%b id=%b exp 0/010", req, flit_id); end
        step(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (err !== 1'b1 || drop_cnt !== 8'd1 || req !== 1'b0) begin n_bad++; $display("FAIL stray_drop err=%b drop=%0d req=%b exp 1/1/0", err, drop_cnt, req); end
        step(1'b0, 1'b0, '0, 1'b0);
        n_cmp++; if (err !== 1'b0 || drop_cnt !== 8'd1 || data_out !== '0) begin n_bad++; $display("FAIL stray_after err=%b drop=%0d data=%h exp 0/1/0", err, drop_cnt, data_out); end
        // An unknown flit type is dropped the same way.
        step(1'b0, 1'b1, flit(BAD, 12'h7, 17'h201), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (err !== 1'b1 || drop_cnt !== 8'd2) begin n_bad++; $display("FAIL stray_bad_type err=%b drop=%0d exp 1/2", err, drop_cnt); end
    endtask

    task automatic test_missing_tail();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, flit(HDR, 12'h003, 17'h300), 1'b0);
        step(1'b0, 1'b1, flit(BODY, 12'h000, 17'h301), 1'b0);
        step(1'b0, 1'b1, flit(HDR, 12'h009, 17'h302), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (flit_id !== HDR || length !== 12'h009 || err !== 1'b0) begin n_bad++; $display("FAIL mt_hdr2_head id=%b len=%h err=%b exp 001/009/0", flit_id, length, err); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (err !== 1'b1 || req !== 1'b1 || data_out !== exp_data()) begin n_bad++; $display("FAIL mt_err err=%b req=%b data=%h exp 1/1/%h", err, req, data_out, exp_data()); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL mt_no_drop drop=%0d exp=0", drop_cnt); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (err !== 1'b0 || data_out !== '0 || req !== 1'b1) begin n_bad++; $display("FAIL mt_hdr2_pop err=%b data=%h req=%b exp 0/0/1", err, data_out, req); end
    endtask

    task automatic test_run_empty();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, flit(HDR, 12'h004, 17'h400), 1'b1);
        step(1'b0, 1'b1, flit(BODY, 12'h000, 17'h401), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (req !== 1'b1 || data_out !== '0 || flit_id !== 3'd0 || length !== 12'd0) begin n_bad++; $display("FAIL re_starved cyc=%0d req=%b data=%h id=%b len=%h", i, req, data_out, flit_id, length); end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        step(1'b0, 1'b1, flit(BODY, 12'h000, 17'h402), 1'b1);
        n_cmp++; if (flit_id !== BODY || data_out !== exp_data()) begin n_bad++; $display("FAIL re_resume id=%b data=%h exp 010/%h", flit_id, data_out, exp_data()); end
        step(1'b0, 1'b1, flit(TAIL, 12'h000, 17'h403), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (req !== 1'b0 || data_out !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL re_done req=%b data=%h err=%b exp 0/0/0", req, data_out, err); end
    endtask

    task automatic test_saturate_and_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 257; i++) begin
            step(1'b0, (i < 256), flit(TAIL, 12'h0, 17'(i)), 1'b0);
            n_cmp++; if (drop_cnt !== 8'(m_drop) || err !== m_err) begin n_bad++; $display("FAIL sat_track i=%0d drop=%0d exp=%0d err=%b exp=%b", i, drop_cnt, m_drop, err, m_err); end
        end
        n_cmp++; if (drop_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_final drop=%0d exp=255", drop_cnt); end
        step(1'b0, 1'b1, flit(HDR, 12'h002, 17'h500), 1'b0);
        step(1'b0, 1'b1, flit(BODY, 12'h000, 17'h501), 1'b1);
        step(1'b0, 1'b1, flit(BODY, 12'h000, 17'h502), 1'b0);
        step(1'b1, 1'b1, flit(BODY, 12'h000, 17'h503), 1'b1);
        n_cmp++; if (ready_out !== 1'b1 || req !== 1'b0 || drop_cnt !== 8'd0 || data_out !== '0) begin n_bad++; $display("FAIL midpkt_rst rdy=%b req=%b drop=%0d data=%h exp 1/0/0/0", ready_out, req, drop_cnt, data_out); end
        step(1'b0, 1'b0, '0, 1'b1);
        n_cmp++; if (data_out !== '0 || req !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midpkt_clean data=%h req=%b err=%b exp 0/0/0", data_out, req, err); end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; grant = 1'b0;
        m_active = 0; m_err = 0; m_drop = 0;
        @(negedge clk);
        test_reset();
        test_packet();
        test_back_to_back();
        test_stray_body();
        test_missing_tail();
        test_run_empty();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in flits (power of 2, minimum 2).
REQ-002 SHALL have parameter FLIT_W, default 32, flit width in bits (minimum 16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 data_in  input  FLIT_W  incoming flit from the link.
REQ-006 valid_in  input  1  data_in is valid this cycle.
REQ-007 ready_out  output  1  buffer can accept a flit this cycle.
REQ-008 grant  input  1  this port owns the crossbar this cycle (one bit of the arbiter one-hot state).
REQ-009 data_out  output  FLIT_W  head flit (first-word fall-through).
REQ-010 flit_id  output  3  head flit type, feeds arbiter timer.
REQ-011 length  output  12  head flit length field, feeds arbiter timer.
REQ-012 req  output  1  request to arbiter.
REQ-013 err  output  1  one-cycle pulse on protocol error.
REQ-014 drop_cnt  output  8  saturating count of discarded flits.

Function
REQ-015 Flit format SHALL be: bits [FLIT_W-1:FLIT_W-3] flit type (3'b001 header, 3'b010 body, 3'b100 tail); bits [11:0] packet length, meaningful only in headers.
REQ-016 ready_out SHALL equal NOT full; a write occurs when valid_in AND ready_out.
REQ-017 Write attempts while full SHALL be ignored, even if a read occurs in the same cycle.
REQ-018 Simultaneous write and read when neither full nor empty SHALL leave occupancy unchanged.
REQ-019 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL range 0..DEPTH.
REQ-020 When not empty, data_out SHALL equal the head entry, flit_id its type bits, and length its bits [11:0].
REQ-021 When empty, data_out, flit_id and length SHALL be 0.
REQ-022 A written flit SHALL appear at the head no earlier than the next cycle; write to an empty FIFO has 1-cycle latency.
REQ-023 FSM states: IDLE and ACTIVE.
REQ-024 IDLE, head is header: req=1; when grant=1, pop the header and go to ACTIVE.
REQ-025 IDLE, head is body, tail or another type: req=0; pop the flit, pulse err, increment drop_cnt; grant ignored.
REQ-026 ACTIVE: req=1 regardless of FIFO occupancy.
REQ-027 ACTIVE, grant=1, not empty, head is body: pop it and stay in ACTIVE.
REQ-028 ACTIVE, grant=1, not empty, head is tail: pop it and go to IDLE.
REQ-029 ACTIVE, head is header (missing tail): do not pop; pulse err; go to IDLE, where the header is served as a new packet.
REQ-030 ACTIVE, head is another type: pop, pulse err, increment drop_cnt, stay in ACTIVE.
REQ-031 ACTIVE, grant=0 or FIFO empty: no pop, state held.
REQ-032 At most one pop per cycle.
REQ-033 drop_cnt SHALL saturate at 255.
REQ-034 err and drop_cnt changes SHALL be registered, visible the cycle after the discard decision.

Reset
REQ-035 On rst=1 at a clock edge: FIFO empty, pointers 0, state IDLE, err=0, drop_cnt=0; hence ready_out=1, req=0, outputs 0 on the following cycle.
REQ-036 A flit presented with valid_in in a reset cycle SHALL NOT be stored.
REQ-037 Reset mid-packet SHALL discard all stored flits and the packet context.

Verification
REQ-038 Write header (len 12'h005), body, tail, then grant held high -> req rises 1 cycle after header write; flit_id sequence 001, 010, 100; length=5 while header at head; state IDLE and req=0 after tail pops.
REQ-039 DEPTH=4, 5 back-to-back writes, no grant -> ready_out=0 after the 4th write; 5th flit not stored; tail popped 4 cycles after grant asserted.
REQ-040 Body flit written while IDLE -> discarded without grant; err pulses 1 cycle; drop_cnt=1; req stays 0.
REQ-041 Header, body, then header (no tail) -> after body pop, second header at head: err pulse, state IDLE, req stays 1, second header popped on next grant.
REQ-042 Grant held through header/body, FIFO runs empty mid-packet -> req stays 1, no pop, outputs 0; resumes when next body arrives.
REQ-043 256 stray tail flits -> drop_cnt saturates at 255; rst mid-packet -> ready_out=1, req=0, drop_cnt=0 next cycle.
